multi_clk_div: RTL and testbench

Multi-channel programmable clock divider and tick generator. Generalises the single fixed-frequency toggle divider to `NCH` independent channels. Each channel has a runtime-programmable limit, a per-channel mode (50 % toggle clock or one-cycle tick), an independent enable, and glitch-free retiming: new settings take effect only at a period boundary. It sits beside the processor's clock/peripheral logic and feeds slow clocks and periodic enables to display, UART-baud and timer blocks.

---
 rtl/multi_clk_div_pkg.sv | 20 ++
 rtl/multi_clk_div_if.sv | 16 +
 rtl/multi_clk_div_chan.sv | 127 ++++++++++++
 rtl/multi_clk_div.sv | 54 +++++
 tb/tb_multi_clk_div.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_clk_div_pkg.sv
// Shared types and constant helpers for the multi-channel clock divider.
// Mode encoding, reset-limit derivation and channel-select width.
package clkdiv_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Terminal count giving a 50 % toggle clock at freq from clk_freq.
    function automatic int unsigned def_limit(input int unsigned clk_freq,
                                              input int unsigned freq);
        return clk_freq / 32'd2 / freq - 32'd1;
    endfunction

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/multi_clk_div_if.sv
// Configuration write port of the divider: one strobe, target channel,
// new terminal count and mode.
interface multi_clk_div_if #(
    parameter int NCH = 4,
    parameter int CW  = 32
);
    localparam int CHW = clkdiv_pkg::ch_width(NCH);

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_limit;
    logic           cfg_mode;

    modport master (output cfg_we, output cfg_ch, output cfg_limit, output cfg_mode);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_limit, input  cfg_mode);
endinterface

// File: rtl/multi_clk_div_chan.sv
// One divider channel: counter, active and shadow settings, registered
// tick/clkout. Settings written while running wait for the next wrap.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int             CW        = 32,
    parameter logic [CW-1:0]  DEF_LIMIT = '0
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          en,
    input  logic          restart,
    input  logic          we,
    input  logic [CW-1:0] cfg_limit,
    input  mode_e         cfg_mode,
    output logic          clkout,
    output logic          tick,
    output logic          pending
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] limit_s_q, limit_s_d;
    mode_e         mode_q, mode_d;
    mode_e         mode_s_q, mode_s_d;
    logic          pending_q, pending_d;
    logic          clkout_q, clkout_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;

    logic wrap;
    logic clk_base;

    assign wrap     = en && (cnt_q >= limit_q);
    // A mode switch at the previous wrap restarts the toggle phase from 0.
    assign clk_base = clr_q ? 1'b0 : clkout_q;

    // NOTE: every signal written here is defaulted first so no path
    // through the if/else tree can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        limit_s_d = limit_s_q;
        mode_s_d  = mode_s_q;
        pending_d = pending_q;
        clkout_d  = clkout_q;
        tick_d    = 1'b0;
        clr_d     = 1'b0;

        if (restart) begin
            cnt_d    = '0;
            clkout_d = 1'b0;
            if (pending_q) begin
                limit_d   = limit_s_q;
                mode_d    = mode_s_q;
                pending_d = 1'b0;
            end
            if (we) begin
                limit_s_d = cfg_limit;
                mode_s_d  = cfg_mode;
                pending_d = 1'b1;
            end
        end else if (we && !en) begin
            // Idle channel: nothing to be glitch-free against, apply at once.
            limit_d   = cfg_limit;
            mode_d    = cfg_mode;
            cnt_d     = '0;
            clkout_d  = 1'b0;
            pending_d = 1'b0;
        end else begin
            if (wrap) begin
                cnt_d    = '0;
                tick_d   = 1'b1;
                clkout_d = (mode_q == MODE_TOGGLE) ? ~clk_base : 1'b1;
                if (pending_q) begin
                    limit_d   = limit_s_q;
                    mode_d    = mode_s_q;
                    pending_d = 1'b0;
                    clr_d     = (mode_s_q != mode_q);
                end
            end else begin
                if (en) begin
                    cnt_d = cnt_q + CW'(1);
                end
                clkout_d = (mode_q == MODE_TOGGLE) ? clk_base : 1'b0;
            end
            // Running channel: last write before the wrap wins the shadow.
            if (we) begin
                limit_s_d = cfg_limit;
                mode_s_d  = cfg_mode;
                pending_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            limit_q   <= DEF_LIMIT;
            mode_q    <= MODE_TOGGLE;
            limit_s_q <= DEF_LIMIT;
            mode_s_q  <= MODE_TOGGLE;
            pending_q <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            limit_s_q <= limit_s_d;
            mode_s_q  <= mode_s_d;
            pending_q <= pending_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
        end
    end

    assign clkout  = clkout_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider / tick generator. Decodes the
// config port into per-channel write strobes and instantiates NCH channels.
module multi_clk_div
    import clkdiv_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          CW       = 32,
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned DEF_FREQ = 500
) (
    input  logic            clkin,
    input  logic            rst_n,
    input  logic [NCH-1:0]  en,
    input  logic            restart,
    multi_clk_div_if.slave  cfg,
    output logic [NCH-1:0]  clkout,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  pending
);

    localparam int            CHW       = ch_width(NCH);
    localparam logic [CW-1:0] DEF_LIMIT = CW'(def_limit(CLK_FREQ, DEF_FREQ));

    logic [NCH-1:0] we_vec;

    // Channel numbers at or above NCH match no strobe and are dropped.
    always_comb begin
        we_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_we && (cfg.cfg_ch == CHW'(i))) begin
                we_vec[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clkdiv_chan #(
            .CW        (CW),
            .DEF_LIMIT (DEF_LIMIT)
        ) u_chan (
            .clkin     (clkin),
            .rst_n     (rst_n),
            .en        (en[i]),
            .restart   (restart),
            .we        (we_vec[i]),
            .cfg_limit (cfg.cfg_limit),
            .cfg_mode  (mode_e'(cfg.cfg_mode)),
            .clkout    (clkout[i]),
            .tick      (tick[i]),
            .pending   (pending[i])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div: five channels, reset limit 9
// (CLK_FREQ 1000, DEF_FREQ 50), hand-computed expectations per edge.
module tb_multi_clk_div;

    localparam int NCH = 5;
    localparam int CW  = 16;

    logic           clkin = 1'b0;
    logic           rst_n;
    logic           restart;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    multi_clk_div_if #(.NCH(NCH), .CW(CW)) cfg_if ();

    multi_clk_div #(
        .NCH      (NCH),
        .CW       (CW),
        .CLK_FREQ (1000),
        .DEF_FREQ (50)
    ) dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .en      (en),
        .restart (restart),
        .cfg     (cfg_if.slave),
        .clkout  (clkout),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic set_cfg(input logic we, input int ch, input int limit, input logic mode);
        cfg_if.cfg_we    = we;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_limit = CW'(limit);
        cfg_if.cfg_mode  = mode;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b1;
        restart = 1'b0;
        en      = '0;
        set_cfg(1'b0, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clkin);
        check("rst_clkout",  8'(clkout),  8'h00);
        check("rst_tick",    8'(tick),    8'h00);
        check("rst_pending", 8'(pending), 8'h00);

        // ch0 default limit 9, toggle
        @(negedge clkin);
        rst_n = 1'b1;
        en    = 5'b00001;
        cyc(9);
        check("ch0_e9",  8'({tick[0], clkout[0]}), 8'h0);
        cyc(1);
        check("ch0_e10", 8'({tick[0], clkout[0]}), 8'h3);
        cyc(1);
        check("ch0_e11", 8'({tick[0], clkout[0]}), 8'h1);
        cyc(9);
        check("ch0_e20", 8'({tick[0], clkout[0]}), 8'h2);

        // ch1 limit 3 toggle, then limit 1 written mid-period
        set_cfg(1'b1, 1, 3, 1'b0);
        cyc(1);
        check("ch1_direct_pend", 8'(pending[1]), 8'h0);
        set_cfg(1'b0, 0, 0, 1'b0);
        en[1] = 1'b1;
        cyc(4);
        check("ch1_f4",  8'({tick[1], clkout[1]}), 8'h3);
        cyc(4);
        check("ch1_f8",  8'({tick[1], clkout[1]}), 8'h2);
        cyc(1);
        set_cfg(1'b1, 1, 1, 1'b0);
        cyc(1);
        set_cfg(1'b0, 0, 0, 1'b0);
        check("ch1_f10_pend", 8'({pending[1], clkout[1]}), 8'h2);
        cyc(1);
        check("ch1_f11_pend", 8'({pending[1], clkout[1]}), 8'h2);
        cyc(1);
        check("ch1_f12_apply", 8'({pending[1], tick[1], clkout[1]}), 8'h3);
        cyc(1);
        check("ch1_f13", 8'({tick[1], clkout[1]}), 8'h1);
        cyc(1);
        check("ch1_f14", 8'({tick[1], clkout[1]}), 8'h2);
        cyc(2);
        check("ch1_f16", 8'({tick[1], clkout[1]}), 8'h3);
        en[1] = 1'b0;

        // ch2 pulse mode limit 2, with a 5-cycle enable gap
        set_cfg(1'b1, 2, 2, 1'b1);
        cyc(1);
        set_cfg(1'b0, 0, 0, 1'b0);
        en[2] = 1'b1;
        cyc(2);
        check("ch2_g2",  8'({tick[2], clkout[2]}), 8'h0);
        cyc(1);
        check("ch2_g3",  8'({tick[2], clkout[2]}), 8'h3);
        cyc(1);
        check("ch2_g4",  8'({tick[2], clkout[2]}), 8'h0);
        cyc(2);
        check("ch2_g6",  8'({tick[2], clkout[2]}), 8'h3);
        cyc(1);
        en[2] = 1'b0;
        cyc(1);
        check("ch2_off_g8",  8'({tick[2], clkout[2]}), 8'h0);
        cyc(4);
        check("ch2_off_g12", 8'({tick[2], clkout[2]}), 8'h0);
        en[2] = 1'b1;
        cyc(1);
        check("ch2_g13", 8'({tick[2], clkout[2]}), 8'h0);
        cyc(1);
        check("ch2_g14", 8'({tick[2], clkout[2]}), 8'h3);
        en[2] = 1'b0;

        // ch3 limit 3, write coinciding with the wrap
        set_cfg(1'b1, 3, 3, 1'b0);
        cyc(1);
        set_cfg(1'b0, 0, 0, 1'b0);
        en[3] = 1'b1;
        cyc(2);
        set_cfg(1'b1, 3, 1, 1'b0);
        cyc(1);
        check("ch3_h3_pend", 8'(pending[3]), 8'h1);
        set_cfg(1'b1, 3, 2, 1'b0);
        cyc(1);
        set_cfg(1'b0, 0, 0, 1'b0);
        check("ch3_h4_wrapwr", 8'({pending[3], tick[3], clkout[3]}), 8'h7);
        cyc(1);
        check("ch3_h5", 8'({pending[3], tick[3]}), 8'h2);
        cyc(1);
        check("ch3_h6", 8'({pending[3], tick[3], clkout[3]}), 8'h2);
        cyc(2);
        check("ch3_h8", 8'(tick[3]), 8'h0);
        cyc(1);
        check("ch3_h9", 8'(tick[3]), 8'h1);

        // out-of-range channel select
        set_cfg(1'b1, NCH, 0, 1'b1);
        cyc(1);
        set_cfg(1'b0, 0, 0, 1'b0);
        check("badch_pending", 8'(pending), 8'h00);
        check("badch_ch1_hold", 8'(clkout[1]), 8'h1);
        cyc(2);
        check("badch_ch3_h12", 8'(tick[3]), 8'h1);

        // restart with ch0 holding a pending limit of 0
        set_cfg(1'b1, 0, 0, 1'b0);
        cyc(1);
        check("rs_pend0", 8'(pending[0]), 8'h1);
        set_cfg(1'b0, 0, 0, 1'b0);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        check("rs_clkout", 8'(clkout),  8'h00);
        check("rs_tick",   8'(tick),    8'h00);
        check("rs_pend",   8'(pending), 8'h00);
        cyc(1);
        check("rs_r2", 8'({tick[0], clkout[0]}), 8'h3);
        cyc(1);
        check("rs_r3", 8'({tick[0], clkout[0]}), 8'h2);
        cyc(1);
        check("rs_r4", 8'(clkout[0]), 8'h1);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_clkout",  8'(clkout),  8'h00);
        check("arst_tick",    8'(tick),    8'h00);
        check("arst_pending", 8'(pending), 8'h00);
        @(negedge clkin);
        rst_n = 1'b1;
        cyc(1);
        check("arst_s1", 8'(tick[0]), 8'h0);
        cyc(8);
        check("arst_s9", 8'(tick[0]), 8'h0);
        cyc(1);
        check("arst_s10", 8'({tick[0], clkout[0]}), 8'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
